// File: rtl/digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_serial_adder                                                         |
// | Multi-cycle add/subtract, DIGIT bits per cycle, start/busy/done handshake. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module digit_serial_adder #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int c_n     = WIDTH / DIGIT;
   localparam int c_idx_w = (c_n > 1) ? $clog2(c_n) : 1;
   localparam int c_msb   = WIDTH - 1;

   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   generate
      if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
         $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   logic [1:0]         state_q, state_d;
   logic [c_idx_w-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               overflow_q, overflow_d;
   logic               zero_q, zero_d;

   logic               accept;
   logic               last_digit;
   logic [DIGIT-1:0]   digit_a;
   logic [DIGIT-1:0]   digit_b;
   logic [DIGIT:0]     digit_sum;
   logic [WIDTH-1:0]   sum_merge;

   assign accept     = start && ((state_q == c_idle) || (state_q == c_done));
   assign last_digit = (state_q == c_run) && (idx_q == c_last_idx);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_idle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle:  if (start) state_d = c_run;
         c_run:   if (last_digit) state_d = c_done;
         c_done:  state_d = start ? c_run : c_idle;
         default: state_d = c_idle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q == c_run);
      done = (state_q == c_done);
   end

   // Select the active digit and splice its result into the running sum.
   always_comb begin
      digit_a = '0;
      digit_b = '0;
      for (int k = 0; k < c_n; k++) begin
         if (int'(idx_q) == k) begin
            digit_a = a_q[k*DIGIT +: DIGIT];
            digit_b = b_q[k*DIGIT +: DIGIT];
         end
      end
      digit_sum = {1'b0, digit_a} + {1'b0, digit_b} + {{DIGIT{1'b0}}, carry_q};
      sum_merge = sum_q;
      for (int k = 0; k < c_n; k++) begin
         if (int'(idx_q) == k) begin
            sum_merge[k*DIGIT +: DIGIT] = digit_sum[DIGIT-1:0];
         end
      end
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      if (accept) begin
         // Subtraction folds into addition of ~B with a forced carry-in of 1.
         a_d     = operand_a;
         b_d     = sub ? ~operand_b : operand_b;
         carry_d = sub | cin;
         idx_d   = '0;
      end else if (state_q == c_run) begin
         sum_d   = sum_merge;
         carry_d = digit_sum[DIGIT];
         idx_d   = idx_q + 1'b1;
         if (last_digit) begin
            idx_d      = '0;
            cout_d     = digit_sum[DIGIT];
            overflow_d = (a_q[c_msb] == b_q[c_msb]) && (sum_merge[c_msb] != a_q[c_msb]);
            zero_d     = (sum_merge == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         carry_q    <= carry_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_digit_serial_adder                                                      |
// | Scoreboard bench for DIGIT = 8, 32 and 1 builds of digit_serial_adder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_digit_serial_adder;

   localparam int W = 32;
   localparam int c_lat [3] = '{5, 2, 33};   // N+1 for DIGIT 8, 32, 1

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
      logic         z;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start_i [3];
   logic         sub_i   [3];
   logic         cin_i   [3];
   logic [W-1:0] a_i     [3];
   logic [W-1:0] b_i     [3];
   logic         busy_o  [3];
   logic         done_o  [3];
   logic [W-1:0] sum_o   [3];
   logic         cout_o  [3];
   logic         ovf_o   [3];
   logic         zero_o  [3];

   int   checks = 0;
   int   errors = 0;
   int   done_cnt [3] = '{0, 0, 0};
   res_t q0 [$];
   res_t q1 [$];
   res_t q2 [$];

   digit_serial_adder #(.WIDTH(W), .DIGIT(8)) u_dut_d8 (
      .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]),
      .operand_a(a_i[0]), .operand_b(b_i[0]), .cin(cin_i[0]),
      .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]),
      .cout(cout_o[0]), .overflow(ovf_o[0]), .zero(zero_o[0]));

   digit_serial_adder #(.WIDTH(W), .DIGIT(32)) u_dut_d32 (
      .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]),
      .operand_a(a_i[1]), .operand_b(b_i[1]), .cin(cin_i[1]),
      .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]),
      .cout(cout_o[1]), .overflow(ovf_o[1]), .zero(zero_o[1]));

   digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_dut_d1 (
      .clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]),
      .operand_a(a_i[2]), .operand_b(b_i[2]), .cin(cin_i[2]),
      .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]),
      .cout(cout_o[2]), .overflow(ovf_o[2]), .zero(zero_o[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic ci, input logic sb);
      logic [W-1:0] be;
      logic [W:0]   t;
      res_t         r;
      be  = sb ? ~bb : bb;
      t   = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      r.s = t[W-1:0];
      r.c = t[W];
      r.v = (aa[W-1] == be[W-1]) && (t[W-1] != aa[W-1]);
      r.z = (t[W-1:0] == '0);
      return r;
   endfunction

   function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic v, input logic z);
      return {s, c, v, z};
   endfunction

   task automatic sb_push(input int id, input res_t r);
      case (id)
         0:       q0.push_back(r);
         1:       q1.push_back(r);
         default: q2.push_back(r);
      endcase
   endtask

   task automatic sb_pop_check(input int id);
      res_t o;
      res_t e;
      int   n;
      o = {sum_o[id], cout_o[id], ovf_o[id], zero_o[id]};
      n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         check($sformatf("dut%0d_spurious_done", id), 64'(done_o[id]), 64'd0);
      end else begin
         case (id)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         check($sformatf("dut%0d_result{sum,cout,ovf,zero}", id), 64'(o), 64'(e));
      end
   endtask

   // Result monitor: every done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done_o[i] === 1'b1) begin
            done_cnt[i]++;
            sb_pop_check(i);
         end
      end
   end

   // Issue one operation at the current negedge, scribble inputs while it runs,
   // and return at the negedge on which done is seen.
   task automatic op(input int id, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic ci, input logic sb, input res_t exp, input string tag);
      int lat;
      a_i[id] = aa; b_i[id] = bb; cin_i[id] = ci; sub_i[id] = sb; start_i[id] = 1'b1;
      sb_push(id, exp);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start_i[id] = busy_o[id] ? 1'($urandom_range(0, 1)) : 1'b0;
         a_i[id]   = $urandom;
         b_i[id]   = $urandom;
         cin_i[id] = 1'($urandom);
         sub_i[id] = 1'($urandom);
      end while ((done_o[id] !== 1'b1) && (lat < 100));
      start_i[id] = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'(c_lat[id]));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           cnt, first, second;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_i[i] = 1'b0; sub_i[i] = 1'b0; cin_i[i] = 1'b0;
         a_i[i] = '0; b_i[i] = '0;
      end
      repeat (3) @(negedge clk);

      check("reset_busy",  64'(busy_o[0]), 64'd0);
      check("reset_done",  64'(done_o[0]), 64'd0);
      check("reset_outs",  64'({sum_o[0], cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
      check("reset_d1_busy", 64'(busy_o[2]), 64'd0);
      rst = 1'b0;

      op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1), "add_wrap");
      op(0, 32'h5, 32'h7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), "sub_5_7");
      op(0, 32'h7, 32'h5, 1'b0, 1'b1, mk(32'h2, 1'b1, 1'b0, 1'b0), "sub_7_5");
      op(0, 32'h0F0F_0F0F, 32'h00F0_F0F0, 1'b1, 1'b0, mk(32'h1000_0000, 1'b0, 1'b0, 1'b0), "add_cin");
      op(0, 32'h5, 32'h5, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1), "sub_cin_ignored");
      op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), "add_ovf");
      op(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), "sub_ovf");

      // Second start during RUN with different operands must be ignored.
      @(negedge clk);
      cnt = done_cnt[0];
      a_i[0] = 32'h1234_5678; b_i[0] = 32'h1111_1111; cin_i[0] = 1'b1; sub_i[0] = 1'b0;
      start_i[0] = 1'b1;
      sb_push(0, mk(32'h2345_678A, 1'b0, 1'b0, 1'b0));
      @(negedge clk); start_i[0] = 1'b0;
      @(negedge clk); start_i[0] = 1'b1; a_i[0] = 32'hDEAD_BEEF; b_i[0] = 32'h0BAD_F00D; sub_i[0] = 1'b1;
      @(negedge clk); start_i[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("ignored_start_done_count", 64'(done_cnt[0] - cnt), 64'd1);

      // Reset mid-RUN (together with a start) aborts with no done pulse.
      op(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), "pre_abort");
      @(negedge clk);
      a_i[0] = 32'h0000_00FF; b_i[0] = 32'h0000_0001; sub_i[0] = 1'b0; cin_i[0] = 1'b0;
      start_i[0] = 1'b1;
      sb_push(0, mk(32'h100, 1'b0, 1'b0, 1'b0));
      @(negedge clk); start_i[0] = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1; start_i[0] = 1'b1;
      @(negedge clk);
      q0.delete();
      cnt = done_cnt[0];
      check("abort_busy", 64'(busy_o[0]), 64'd0);
      check("abort_done", 64'(done_o[0]), 64'd0);
      check("abort_outs", 64'({sum_o[0], cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
      rst = 1'b0; start_i[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_no_done", 64'(done_cnt[0] - cnt), 64'd0);

      // Start held through DONE: back-to-back results N+1 cycles apart.
      a_i[0] = 32'h0000_0001; b_i[0] = 32'h0000_0002; sub_i[0] = 1'b0; cin_i[0] = 1'b0;
      start_i[0] = 1'b1;
      sb_push(0, mk(32'h3, 1'b0, 1'b0, 1'b0));
      first = -1; second = -1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (done_o[0] === 1'b1) begin
            if (first < 0) begin
               first = k;
               a_i[0] = 32'h0000_0010; b_i[0] = 32'h0000_0020; sub_i[0] = 1'b1;
               sb_push(0, mk(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0));
            end else if (second < 0) begin
               second = k;
            end
         end
         if ((first > 0) && (k == first + 1)) start_i[0] = 1'b0;
      end
      start_i[0] = 1'b0;
      check("b2b_first_done_cycle", 64'(first), 64'd5);
      check("b2b_done_spacing", 64'(second - first), 64'd5);

      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
         ra = (i % 16 == 0) ? 32'h8000_0000 : $urandom;
         rb = (i % 16 == 1) ? 32'hFFFF_FFFF : $urandom;
         rc = 1'($urandom); rs = 1'($urandom);
         op(1, ra, rb, rc, rs, model(ra, rb, rc, rs), "d32_rand");
      end
      for (int i = 0; i < 1000; i++) begin
         ra = (i % 16 == 0) ? 32'h7FFF_FFFF : $urandom;
         rb = (i % 16 == 1) ? 32'h0000_0000 : $urandom;
         rc = 1'($urandom); rs = 1'($urandom);
         op(2, ra, rb, rc, rs, model(ra, rb, rc, rs), "d1_rand");
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
